serial_add_sub: RTL and testbench

Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop. It processes one bit per clock, LSB first, over WIDTH cycles, and reports sum, carry-out and signed overflow through a start/ready/done handshake. It is the multi-bit, sequential successor to the 1-bit full adder in the arith library, for area-constrained datapaths where latency is acceptable.

---
 rtl/serial_add_sub_if.sv | 25 ++
 rtl/serial_add_sub.sv | 117 +++++++++++
 tb/tb_serial_add_sub.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sub_if.sv
// Handshake and data bundle for the bit-serial adder/subtractor.
// The master side issues operations; the slave side (the adder) returns results.
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  ready, done, s, co, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output ready, done, s, co, ovf
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// one bit per clock over WIDTH cycles. Subtraction is a + ~b + 1, with the +1
// injected as the initial carry.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_add_sub_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic             sum_bit;
  logic             carry_nxt;

  // Single full-adder cell operating on the current LSBs.
  always_comb begin
    sum_bit   = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    carry_nxt = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) | (op_b_q[0] & carry_q);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_a_d  = bus.a;
          op_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        carry_d = carry_nxt;
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // On the MSB step carry_q is the carry into bit WIDTH-1, so no
          // separate capture register is needed for the overflow term.
          s_d     = {sum_bit, res_q[WIDTH-1:1]};
          co_d    = carry_nxt;
          ovf_d   = carry_q ^ carry_nxt;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake and result outputs are pure register decodes.
  always_comb begin
    bus.ready = (state_q == StIdle);
    bus.done  = (state_q == StDone);
    bus.s     = s_q;
    bus.co    = co_q;
    bus.ovf   = ovf_q;
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub at WIDTH=8 and WIDTH=4.
module tb_serial_add_sub;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_add_sub_if #(.WIDTH(8)) bus8 ();
  serial_add_sub_if #(.WIDTH(4)) bus4 ();

  serial_add_sub #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_add_sub #(.WIDTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full 8-bit operation with handshake, latency and result checks.
  task automatic run8(input string tag, input logic sub, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_s, input logic exp_co, input logic exp_ovf);
    int lat;
    bus8.start = 1'b1;
    bus8.sub   = sub;
    bus8.a     = a;
    bus8.b     = b;
    tick();
    bus8.start = 1'b0;
    chk({tag, "_ready_low"}, 32'(bus8.ready), 32'd0);
    lat = 0;
    while (!bus8.done && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_s"}, 32'(bus8.s), 32'(exp_s));
    chk({tag, "_co"}, 32'(bus8.co), 32'(exp_co));
    chk({tag, "_ovf"}, 32'(bus8.ovf), 32'(exp_ovf));
    tick();
    chk({tag, "_done_drop"}, 32'(bus8.done), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus8.ready), 32'd1);
  endtask

  task automatic run4(input logic sub, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] exp_s, input logic exp_co, input logic exp_ovf);
    int lat;
    bus4.start = 1'b1;
    bus4.sub   = sub;
    bus4.a     = a;
    bus4.b     = b;
    tick();
    bus4.start = 1'b0;
    lat = 0;
    while (!bus4.done && lat < 40) begin
      tick();
      lat++;
    end
    chk("exh_latency", 32'(lat), 32'd4);
    chk("exh_s", 32'(bus4.s), 32'(exp_s));
    chk("exh_co", 32'(bus4.co), 32'(exp_co));
    chk("exh_ovf", 32'(bus4.ovf), 32'(exp_ovf));
    tick();
    chk("exh_done_once", 32'(bus4.done), 32'd0);
  endtask

  initial begin
    logic [3:0] bb;
    logic [4:0] full;
    logic [3:0] es;
    logic       eco;
    logic       eovf;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = '0; bus4.b = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_ready", 32'(bus8.ready), 32'd1);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_s", 32'(bus8.s), 32'd0);
    chk("rst_co", 32'(bus8.co), 32'd0);
    chk("rst_ovf", 32'(bus8.ovf), 32'd0);

    // Basic addition and corner cases.
    run8("add_0f_01", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
    run8("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run8("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run8("add_80_80", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

    // Subtraction.
    run8("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    run8("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    run8("sub_10_10", 1'b1, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0);

    // Start held high, inputs scrambled while busy; previous result is 00/co=1/ovf=0.
    bus8.start = 1'b1; bus8.sub = 1'b0; bus8.a = 8'h3C; bus8.b = 8'h55;
    tick();
    chk("hold1_ready_low", 32'(bus8.ready), 32'd0);
    for (int i = 0; i < 7; i++) begin
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sub = 1'($urandom);
      tick();
      chk("hold1_done_low", 32'(bus8.done), 32'd0);
      chk("hold1_stable", 32'({bus8.co, bus8.ovf, bus8.s}), 32'h200);
    end
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sub = 1'($urandom);
    tick();
    chk("hold1_done", 32'(bus8.done), 32'd1);
    chk("hold1_res", 32'({bus8.co, bus8.ovf, bus8.s}), 32'h191);
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sub = 1'($urandom);
    tick();
    chk("hold_gap_ready", 32'(bus8.ready), 32'd1);
    chk("hold_gap_done", 32'(bus8.done), 32'd0);
    chk("hold_gap_res", 32'({bus8.co, bus8.ovf, bus8.s}), 32'h191);
    bus8.sub = 1'b1; bus8.a = 8'hA0; bus8.b = 8'h30;
    tick();
    chk("hold2_ready_low", 32'(bus8.ready), 32'd0);
    for (int i = 0; i < 7; i++) begin
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sub = 1'($urandom);
      tick();
      chk("hold2_done_low", 32'(bus8.done), 32'd0);
      chk("hold2_stable", 32'({bus8.co, bus8.ovf, bus8.s}), 32'h191);
    end
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sub = 1'($urandom);
    tick();
    chk("hold2_done", 32'(bus8.done), 32'd1);
    chk("hold2_res", 32'({bus8.co, bus8.ovf, bus8.s}), 32'h370);
    bus8.start = 1'b0;
    tick();
    chk("hold2_ready_back", 32'(bus8.ready), 32'd1);

    // Reset on the third RUN edge aborts the operation.
    bus8.start = 1'b1; bus8.sub = 1'b0; bus8.a = 8'hAA; bus8.b = 8'h11;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(bus8.ready), 32'd1);
    chk("abort_done", 32'(bus8.done), 32'd0);
    chk("abort_s", 32'(bus8.s), 32'd0);
    chk("abort_co", 32'(bus8.co), 32'd0);
    chk("abort_ovf", 32'(bus8.ovf), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_no_done", 32'(bus8.done), 32'd0);
    end
    run8("post_abort", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

    // Exhaustive WIDTH=4 sweep against a reference model.
    for (int sb = 0; sb < 2; sb++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          bb   = (sb != 0) ? ~4'(ib) : 4'(ib);
          full = 5'(ia) + 5'(bb) + 5'(sb);
          es   = full[3:0];
          eco  = full[4];
          eovf = (ia[3] == bb[3]) && (es[3] != ia[3]);
          run4(1'(sb), 4'(ia), 4'(ib), es, eco, eovf);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
